// File: rtl/mat_pkg.sv
// mat_pkg: shared widths and write-FSM encoding for the two-slot matrix store.
package mat_pkg;
   localparam int DIM_WIDTH  = 3;
   localparam int DATA_WIDTH = 8;
   localparam int NUM_SLOTS  = 2;
   localparam int ADDR_WIDTH = 1 + 2 * DIM_WIDTH;
   typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} wstate_e;
endpackage

// File: rtl/mat_store_if.sv
// mat_store_if: load stream, metadata query and element read bus of the matrix store.
interface mat_store_if;
   import mat_pkg::*;
   logic                  wr_start;
   logic                  wr_slot;
   logic [DIM_WIDTH-1:0]  wr_m;
   logic [DIM_WIDTH-1:0]  wr_n;
   logic                  wr_valid;
   logic [DATA_WIDTH-1:0] wr_elem;
   logic                  wr_busy;
   logic                  wr_done;
   logic                  wr_error;
   logic [NUM_SLOTS-1:0]  slot_valid;
   logic                  meta_sel;
   logic [DIM_WIDTH-1:0]  meta_m;
   logic [DIM_WIDTH-1:0]  meta_n;
   logic                  rd_en;
   logic                  rd_slot_idx;
   logic [DIM_WIDTH-1:0]  rd_row_idx;
   logic [DIM_WIDTH-1:0]  rd_col_idx;
   logic [DATA_WIDTH-1:0] rd_elem;
   logic                  rd_elem_valid;
   logic                  rd_err;
   modport master (
      output wr_start, wr_slot, wr_m, wr_n, wr_valid, wr_elem, meta_sel,
             rd_en, rd_slot_idx, rd_row_idx, rd_col_idx,
      input  wr_busy, wr_done, wr_error, slot_valid, meta_m, meta_n,
             rd_elem, rd_elem_valid, rd_err
   );
   modport slave (
      input  wr_start, wr_slot, wr_m, wr_n, wr_valid, wr_elem, meta_sel,
             rd_en, rd_slot_idx, rd_row_idx, rd_col_idx,
      output wr_busy, wr_done, wr_error, slot_valid, meta_m, meta_n,
             rd_elem, rd_elem_valid, rd_err
   );
endinterface

// File: rtl/mat_store_ram.sv
// mat_store_ram: simple dual-port element RAM, one write port and one registered read port.
module mat_store_ram
   import mat_pkg::*;
#(
   parameter int AW = ADDR_WIDTH,
   parameter int DW = DATA_WIDTH
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);
   logic [DW-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem[raddr_i];
   end
endmodule

// File: rtl/mat_store.sv
// mat_store: two-slot matrix store with raster-order loader and edge-triggered read responder.
module mat_store
   import mat_pkg::*;
(
   input logic        clk,
   input logic        rst_n,
   mat_store_if.slave bus
);
   wstate_e                               state_q, state_d;
   logic                                  slot_q, slot_d;
   logic [DIM_WIDTH-1:0]                  m_q, m_d, n_q, n_d, row_q, row_d, col_q, col_d;
   logic [NUM_SLOTS-1:0]                  valid_q, valid_d;
   logic [NUM_SLOTS-1:0][DIM_WIDTH-1:0]   sm_q, sm_d, sn_q, sn_d;
   logic                                  done_q, done_d, error_q, error_d;
   logic                                  rd_en_q, rd_vld_q, rd_vld_d, rd_err_q, rd_err_d;
   logic                                  legal_q, legal_d;
   logic                                  rd_req, legal, we, col_wrap, last;
   logic [DATA_WIDTH-1:0]                 ram_q;

   assign rd_req   = bus.rd_en & ~rd_en_q;
   assign legal    = valid_q[bus.rd_slot_idx] && (bus.rd_row_idx < sm_q[bus.rd_slot_idx])
                     && (bus.rd_col_idx < sn_q[bus.rd_slot_idx]);
   assign we       = (state_q == W_FILL) && bus.wr_valid;
   assign col_wrap = col_q == n_q - 1'b1;
   assign last     = we && col_wrap && (row_q == m_q - 1'b1);

   always_comb begin
      state_d  = state_q;
      slot_d   = slot_q;
      m_d      = m_q;
      n_d      = n_q;
      row_d    = row_q;
      col_d    = col_q;
      valid_d  = valid_q;
      sm_d     = sm_q;
      sn_d     = sn_q;
      done_d   = 1'b0;
      error_d  = 1'b0;
      if (state_q == W_IDLE && bus.wr_start) begin
         if (bus.wr_m != '0 && bus.wr_n != '0) begin
            state_d              = W_FILL;
            slot_d               = bus.wr_slot;
            m_d                  = bus.wr_m;
            n_d                  = bus.wr_n;
            row_d                = '0;
            col_d                = '0;
            valid_d[bus.wr_slot] = 1'b0;
         end else error_d = 1'b1;
      end
      if (we) begin
         col_d = col_wrap ? '0 : col_q + 1'b1;
         row_d = col_wrap ? row_q + 1'b1 : row_q;
      end
      // Commit happens on the same edge that stores the final element.
      if (last) begin
         state_d         = W_IDLE;
         valid_d[slot_q] = 1'b1;
         sm_d[slot_q]    = m_q;
         sn_d[slot_q]    = n_q;
         done_d          = 1'b1;
      end
      rd_vld_d = rd_req;
      rd_err_d = rd_req & ~legal;
      legal_d  = rd_req ? legal : legal_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= W_IDLE;
         slot_q   <= 1'b0;
         m_q      <= '0;
         n_q      <= '0;
         row_q    <= '0;
         col_q    <= '0;
         valid_q  <= '0;
         sm_q     <= '0;
         sn_q     <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         rd_vld_q <= 1'b0;
         rd_err_q <= 1'b0;
         legal_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         m_q      <= m_d;
         n_q      <= n_d;
         row_q    <= row_d;
         col_q    <= col_d;
         valid_q  <= valid_d;
         sm_q     <= sm_d;
         sn_q     <= sn_d;
         done_q   <= done_d;
         error_q  <= error_d;
         rd_en_q  <= bus.rd_en;
         rd_vld_q <= rd_vld_d;
         rd_err_q <= rd_err_d;
         legal_q  <= legal_d;
      end
   end

   mat_store_ram u_ram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i ({slot_q, row_q, col_q}),
      .wdata_i (bus.wr_elem),
      .re_i    (rd_req),
      .raddr_i ({bus.rd_slot_idx, bus.rd_row_idx, bus.rd_col_idx}),
      .rdata_o (ram_q)
   );

   // RAM output holds between requests, so gating it with the held legality keeps rd_elem stable.
   assign bus.rd_elem       = legal_q ? ram_q : '0;
   assign bus.rd_elem_valid = rd_vld_q;
   assign bus.rd_err        = rd_err_q;
   assign bus.wr_busy       = state_q == W_FILL;
   assign bus.wr_done       = done_q;
   assign bus.wr_error      = error_q;
   assign bus.slot_valid    = valid_q;
   assign bus.meta_m        = sm_q[bus.meta_sel];
   assign bus.meta_n        = sn_q[bus.meta_sel];
endmodule

// File: tb/tb_mat_store.sv
// tb_mat_store: random loads/reads against an array model; a monitor checks every read response.
module tb_mat_store;
   import mat_pkg::*;

   typedef struct {
      logic [7:0] d;
      logic       e;
      int         due;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         n_chk = 0, n_fail = 0, cyc = 0;
   exp_t       q[$];
   exp_t       e_m;
   logic [7:0] got[$];
   logic [7:0] mem [2][8][8];
   logic [7:0] ld [64];
   logic       mv [2];
   int         mm [2], mn [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mat_store_if bus ();
   mat_store dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (rst_n) begin
      if (bus.rd_err && !bus.rd_elem_valid) chk("rd_err_without_valid", 1, 0);
      if (bus.rd_elem_valid) begin
         if (q.size() == 0) chk("unexpected_response", 1, 0);
         else begin
            e_m = q.pop_front();
            chk("rd_elem", bus.rd_elem, e_m.d);
            chk("rd_err", bus.rd_err, e_m.e);
            chk("rd_latency", cyc, e_m.due);
            got.push_back(bus.rd_elem);
         end
      end
   end

   // Caller is at a negedge with rd_en low; address is held for the cycle before the rise.
   task automatic rd(input int s, input int r, input int c, input int hold);
      bit legal;
      bus.rd_slot_idx = s[0];
      bus.rd_row_idx  = r[2:0];
      bus.rd_col_idx  = c[2:0];
      @(negedge clk);
      bus.rd_en = 1'b1;
      legal = mv[s] && r < mm[s] && c < mn[s];
      q.push_back('{d: legal ? mem[s][r][c] : 8'd0, e: !legal, due: cyc + 1});
      repeat (hold) @(negedge clk);
      bus.rd_en = 1'b0;
   endtask

   task automatic load(input int s, input int m, input int n, input bit rnd);
      bus.wr_start = 1'b1;
      bus.wr_slot  = s[0];
      bus.wr_m     = m[2:0];
      bus.wr_n     = n[2:0];
      @(negedge clk);
      bus.wr_start = 1'b0;
      if (m == 0 || n == 0) begin
         chk("wr_error", bus.wr_error, 1);
         chk("slot_valid_after_error", bus.slot_valid, {mv[1], mv[0]});
         chk("wr_busy_after_error", bus.wr_busy, 0);
         return;
      end
      mv[s] = 1'b0;
      chk("wr_busy_fill", bus.wr_busy, 1);
      chk("slot_valid_cleared", bus.slot_valid[s], 0);
      for (int i = 0; i < m * n; i++) begin
         if (rnd) repeat ($urandom_range(0, 2)) begin
            bus.wr_start = 1'b1;
            bus.wr_slot  = ~s[0];
            bus.wr_m     = 3'd1;
            bus.wr_n     = 3'd1;
            @(negedge clk);
            bus.wr_start = 1'b0;
         end
         bus.wr_valid = 1'b1;
         bus.wr_elem  = ld[i];
         @(negedge clk);
         bus.wr_valid = 1'b0;
         mem[s][i / n][i % n] = ld[i];
         chk("wr_done", bus.wr_done, i == m * n - 1);
      end
      mm[s] = m;
      mn[s] = n;
      mv[s] = 1'b1;
      chk("slot_valid_set", bus.slot_valid[s], 1);
      chk("wr_busy_end", bus.wr_busy, 0);
   endtask

   task automatic meta_chk();
      for (int s = 0; s < 2; s++) begin
         bus.meta_sel = s[0];
         #1;
         chk("meta_m", bus.meta_m, mm[s]);
         chk("meta_n", bus.meta_n, mn[s]);
      end
   endtask

   task automatic reset_chk();
      rst_n = 1'b0;
      #1;
      chk("rst_wr_busy", bus.wr_busy, 0);
      chk("rst_wr_done", bus.wr_done, 0);
      chk("rst_wr_error", bus.wr_error, 0);
      chk("rst_slot_valid", bus.slot_valid, 0);
      chk("rst_rd_elem", bus.rd_elem, 0);
      chk("rst_rd_elem_valid", bus.rd_elem_valid, 0);
      chk("rst_rd_err", bus.rd_err, 0);
      chk("rst_meta_m", bus.meta_m, 0);
      chk("rst_meta_n", bus.meta_n, 0);
      for (int s = 0; s < 2; s++) begin
         mv[s] = 1'b0;
         mm[s] = 0;
         mn[s] = 0;
      end
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      {bus.wr_start, bus.wr_slot, bus.wr_m, bus.wr_n, bus.wr_valid, bus.wr_elem} = '0;
      {bus.meta_sel, bus.rd_en, bus.rd_slot_idx, bus.rd_row_idx, bus.rd_col_idx} = '0;
      @(negedge clk);
      reset_chk();
      for (int i = 0; i < 6; i++) ld[i] = 8'(i + 1);
      load(0, 2, 3, 0);
      meta_chk();
      rd(0, 1, 2, 1);
      rd(0, 0, 0, 5);
      rd(0, 1, 0, 1);
      rd(0, 2, 0, 1);
      rd(1, 0, 0, 1);
      rd(0, 0, 3, 2);
      @(negedge clk);
      load(0, 0, 3, 0);
      load(1, 4, 0, 0);
      for (int i = 0; i < 2; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_elem  = 8'hEE;
         @(negedge clk);
      end
      bus.wr_valid = 1'b0;
      rd(0, 0, 0, 1);
      // Slot 1 fill overlapped with reads of both slots.
      for (int i = 0; i < 9; i++) ld[i] = 8'($urandom);
      fork
         load(1, 3, 3, 1);
         begin
            repeat (3) @(negedge clk);
            rd(1, 0, 0, 1);
            rd(0, 1, 1, 2);
            rd(0, 0, 2, 1);
         end
      join
      @(negedge clk);
      rd(1, 2, 2, 1);
      repeat (3) @(negedge clk);
      // Reset after three of six elements of a reload.
      bus.wr_start = 1'b1;
      bus.wr_slot  = 1'b0;
      bus.wr_m     = 3'd2;
      bus.wr_n     = 3'd3;
      @(negedge clk);
      bus.wr_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.wr_valid = 1'b1;
         bus.wr_elem  = 8'(i + 50);
         @(negedge clk);
      end
      bus.wr_valid = 1'b0;
      reset_chk();
      chk("slot0_after_midfill_reset", bus.slot_valid[0], 0);
      rd(0, 0, 0, 1);
      @(negedge clk);
      // Matrix-add style traffic: alternate A/B element reads and sum pairs.
      for (int i = 0; i < 4; i++) ld[i] = 8'(i + 1);
      load(0, 2, 2, 0);
      for (int i = 0; i < 4; i++) ld[i] = 8'((i + 1) * 10);
      load(1, 2, 2, 0);
      repeat (3) @(negedge clk);
      got.delete();
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            rd(0, i, j, 1);
            rd(1, i, j, 2);
         end
      repeat (3) @(negedge clk);
      chk("add_response_count", got.size(), 8);
      if (got.size() == 8)
         for (int k = 0; k < 4; k++) chk("add_sum", got[2*k] + got[2*k+1], (k + 1) * 11);
      for (int it = 0; it < 8; it++) begin
         int s, m, n;
         s = $urandom_range(0, 1);
         m = $urandom_range(0, 7);
         n = $urandom_range(0, 7);
         for (int i = 0; i < 64; i++) ld[i] = 8'($urandom);
         load(s, m, n, 1);
         meta_chk();
         repeat (10) rd($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(1, 3));
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
